fft_input_buffer: RTL

- Sits directly upstream of FFT_PE and collects the real-valued FIR output stream into 16-sample frames.
- Uses a ping-pong buffer: while one bank fills, the other bank drains.
- For each completed frame it emits the 8 first-stage radix-2 DIF butterfly operand pairs (x[n], x[n+8]) with twiddle index n, in FFT_PE's {real,imag} 32-bit format.
- Input is never stalled: a full drain takes 8 cycles, a frame fill takes at least 16.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_pingpong_ram.sv | 26 ++
 rtl/fft_input_buffer.sv | 100 ++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT front end (input buffer and FFT_PE).
package fft_pkg;

  localparam int unsigned DW   = 16;
  localparam int unsigned N    = 16;
  localparam int unsigned PW   = 3;
  localparam int unsigned HALF = N / 2;
  localparam int unsigned AW   = $clog2(N);

  // Complex sample as consumed by FFT_PE: real in [31:16], imag in [15:0].
  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } cplx_t;

  typedef enum logic {
    RD_IDLE,
    RD_DRAIN
  } rd_state_t;

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank 16-entry sample store: one write port, and a read port that
// returns the butterfly pair (entry raddr and entry raddr+8) of one bank.
module fft_pingpong_ram
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic          wbank,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          rbank,
  input  logic [AW-2:0] raddr,
  output logic [DW-1:0] rdata_lo,
  output logic [DW-1:0] rdata_hi
);

  logic [DW-1:0] mem [2][N];

  always_ff @(posedge clk) begin
    if (we) mem[wbank][waddr] <= wdata;
  end

  assign rdata_lo = mem[rbank][{1'b0, raddr}];
  assign rdata_hi = mem[rbank][{1'b1, raddr}];

endmodule

// File: rtl/fft_input_buffer.sv
// Collects 16-sample frames into a ping-pong buffer and emits the eight
// first-stage radix-2 DIF operand pairs (x[n], x[n+8]) per completed frame.
module fft_input_buffer #(
  parameter int unsigned DW = 16,
  parameter int unsigned N  = 16,
  parameter int unsigned PW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] fir_d,
  input  logic          fir_valid,
  output logic [2*DW-1:0] a,
  output logic [2*DW-1:0] b,
  output logic          ab_valid,
  output logic [PW-1:0] power,
  output logic          frame_done
);

  import fft_pkg::*;

  localparam int unsigned CW = $clog2(N);

  logic [CW-1:0] wcnt;
  logic          wb;
  logic          rbank;
  logic          pending;
  rd_state_t     state;
  logic [CW-2:0] rcnt;
  logic [DW-1:0] rd_lo;
  logic [DW-1:0] rd_hi;
  logic          wr_last;

  assign wr_last = fir_valid && (wcnt == CW'(N - 1));

  fft_pingpong_ram u_ram (
    .clk      (clk),
    .we       (fir_valid),
    .wbank    (wb),
    .waddr    (wcnt),
    .wdata    (fir_d),
    .rbank    (rbank),
    .raddr    (rcnt),
    .rdata_lo (rd_lo),
    .rdata_hi (rd_hi)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt  <= '0;
      wb    <= 1'b0;
      rbank <= 1'b0;
    end else if (fir_valid) begin
      wcnt <= wcnt + 1'b1;
      if (wr_last) begin
        wb    <= ~wb;
        rbank <= wb;
      end
    end
  end

  // A completion arriving while draining sets pending; it is only consumed
  // from IDLE, so a frame completed mid-drain is serviced right after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RD_IDLE;
      pending    <= 1'b0;
      rcnt       <= '0;
      a          <= '0;
      b          <= '0;
      power      <= '0;
      ab_valid   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (wr_last) pending <= 1'b1;
      else if (state == RD_IDLE) pending <= 1'b0;

      case (state)
        RD_IDLE: begin
          ab_valid   <= 1'b0;
          frame_done <= 1'b0;
          if (pending) begin
            state <= RD_DRAIN;
            rcnt  <= '0;
          end
        end
        RD_DRAIN: begin
          a          <= cplx_t'{re: rd_lo, im: '0};
          b          <= cplx_t'{re: rd_hi, im: '0};
          power      <= PW'(rcnt);
          ab_valid   <= 1'b1;
          rcnt       <= rcnt + 1'b1;
          frame_done <= (rcnt == (CW-1)'(HALF - 1));
          if (rcnt == (CW-1)'(HALF - 1)) state <= RD_IDLE;
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

endmodule
